tick_sequencer: RTL and testbench
=================================

# tick_sequencer

Programmable phase sequencer for the tick-timing path. It owns a resettable tick prescaler, steps through up to NUM_PHASES timed phases, and holds each phase for a configured number of ticks. It reports the active phase index to downstream display/LED logic. Software or a top-level FSM loads the durations, pulses start, and waits for done.

## Interface
- SRC_FREQ, 5000: source clock frequency in Hz.
- TICK_FREQ, 1: tick rate in Hz. DIV = SRC_FREQ/TICK_FREQ (integer division, must be ≥ 2).
- NUM_PHASES, 4: number of duration registers, ≥ 2. PH_W = $clog2(NUM_PHASES).
- DUR_W, 8: width of each duration register, in ticks.
- src_clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cfg_we  in  1  write strobe for the duration register.
- cfg_addr  in  PH_W  duration register index.
- cfg_dur  in  DUR_W  phase duration in ticks.
- seq_last  in  PH_W  index of the final phase; sampled when start is accepted.
- start  in  1  begin a sequence; level-sampled, acted on only in IDLE.
- abort  in  1  terminate the sequence immediately.
- busy  out  1  high while the sequence runs.
- phase  out  PH_W  current phase index.
- tick_pulse  out  1  one-cycle pulse every DIV cycles while running.
- done  out  1  one-cycle pulse after the final phase completes.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start=1 and abort=0.
  - RUN → DONE on the final tick of phase seq_last.
  - RUN → IDLE on abort.
  - DONE → IDLE unconditionally.
- Reset values: state IDLE, busy 0, phase 0, tick_pulse 0, done 0, prescaler 0, tick counter 0. All duration registers reset to 1.
- Config: a cfg_we write takes effect at the clock edge, but only in IDLE or DONE. Writes are ignored during RUN. Writes with cfg_addr ≥ NUM_PHASES are ignored.
- A duration value of 0 is treated as 1.
- On start acceptance:
  - latch last = min(seq_last, NUM_PHASES-1);
  - clear the prescaler and the tick counter;
  - set phase to 0.
- Prescaler: counts 0..DIV-1 in RUN and wraps. tick_pulse = (state==RUN && cnt==DIV-1). The prescaler is held at 0 outside RUN.
- Each tick_pulse increments the tick counter.
- Phase end: on a tick_pulse where the tick counter equals dur[phase]-1, the phase ends.
  - If phase < last: phase increments and the tick counter clears.
  - If phase == last: go to DONE. phase holds its value through DONE and returns to 0 on entry to IDLE.
- busy = (state==RUN). done = (state==DONE).
- abort has priority over tick and phase advance in the same cycle. It is ignored in IDLE and DONE.
- start during RUN or DONE is ignored. A sequence is not queued.

## Timing
- start sampled at edge E → busy=1 and phase=0 from E+1.
- First tick_pulse occurs in the DIV-th RUN cycle. Consecutive pulses are exactly DIV cycles apart.
- Phase p occupies max(dur[p],1)·DIV cycles.
- Total busy time is Σ max(dur[p],1)·DIV cycles for p = 0..last. done is high in the following single cycle.
- Earliest restart: start may be accepted in the cycle after DONE. Back-to-back sequences have a 2-cycle gap, busy low for DONE + IDLE.
- abort sampled at edge E → busy=0 and phase=0 from E+1. No done pulse. The prescaler restarts from 0 on the next start.
- rst_n low mid-sequence forces all outputs to reset values asynchronously. Durations return to 1.

## Structure
- The shared package holds the FSM state enum (IDLE, RUN, DONE) and the DIV computation helper, for reuse by other tick-domain blocks.
- One sub-module: tick_prescaler (parameters DIV; ports src_clk, rst_n, run, pulse). It is a resettable, pulse-output counterpart to the free-running toggle tick generator.
- The duration register file, tick counter and FSM stay in tick_sequencer.

## Test plan
All tests use SRC_FREQ=4 and TICK_FREQ=1, so DIV=4.
- Reset → busy=0, phase=0, done=0, tick_pulse=0. Start with seq_last=1 and default durations → phase 0 for 4 cycles, phase 1 for 4 cycles, done one cycle later.
- Load dur = {3,1,2,0}, seq_last=3, start → phase spans 12/4/8/4 cycles, total busy 28 cycles. tick_pulse every 4th cycle. done at cycle 29.
- Load dur[0]=5, start, assert abort in RUN cycle 10 → busy=0 and phase=0 next cycle, no done. Restart → first tick_pulse again exactly 4 cycles after busy rises.
- Write cfg_addr=0, cfg_dur=9 during RUN → value ignored; the next run still uses the old duration. start held high during RUN → no second sequence.
- start and abort both high in IDLE → stay IDLE. seq_last=3 with NUM_PHASES=3 → clamped to 2.
- rst_n pulsed low mid-phase 2 → outputs drop to reset values immediately. Durations read back as 1 (next run: 4 cycles per phase).

Source files
------------

// File: rtl/tick_sequencer_pkg.sv
// Shared definitions for tick-domain blocks: sequencer FSM state encoding and
// the prescaler divide-ratio helper.
package tick_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Source cycles per tick; callers must keep the ratio at 2 or more.
    function automatic int tick_div(input int src_freq, input int tick_freq);
        return src_freq / tick_freq;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Resettable tick prescaler: counts 0..DIV-1 while run is high and emits a
// single-cycle pulse on the terminal count. The count is held at 0 while idle.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic src_clk,
    input  logic rst_n,
    input  logic run,
    output logic pulse
);

    localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || (cnt == CNT_MAX)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign pulse = run && (cnt == CNT_MAX);

endmodule

// File: rtl/tick_sequencer.sv
// Programmable phase sequencer: holds each phase for a configured number of
// ticks, reports the active phase, and pulses done after the final phase.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for start; duration registers writable
//   ST_RUN  | prescaler running, stepping phases 0..last
//   ST_DONE | single-cycle completion pulse; registers writable
module tick_sequencer
    import tick_sequencer_pkg::*;
#(
    parameter  int SRC_FREQ   = 5000,
    parameter  int TICK_FREQ  = 1,
    parameter  int NUM_PHASES = 4,
    parameter  int DUR_W      = 8,
    localparam int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic              src_clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [PH_W-1:0]   cfg_addr,
    input  logic [DUR_W-1:0]  cfg_dur,
    input  logic [PH_W-1:0]   seq_last,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic [PH_W-1:0]   phase,
    output logic              tick_pulse,
    output logic              done
);

    localparam int              DIV        = tick_div(SRC_FREQ, TICK_FREQ);
    localparam logic [PH_W-1:0] LAST_MAX   = PH_W'(NUM_PHASES - 1);
    localparam logic [PH_W:0]   NUM_PH_EXT = (PH_W + 1)'(NUM_PHASES);

    seq_state_e       state_q;
    seq_state_e       state_d;

    logic [DUR_W-1:0] dur_q [NUM_PHASES];
    logic [DUR_W-1:0] dur_cur;
    logic [DUR_W-1:0] dur_eff;
    logic [DUR_W-1:0] tick_cnt_q;
    logic [PH_W-1:0]  phase_q;
    logic [PH_W-1:0]  last_q;

    logic run_en;
    logic start_acc;
    logic abort_run;
    logic phase_end;
    logic final_end;
    logic cfg_ok;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .src_clk (src_clk),
        .rst_n   (rst_n),
        .run     (run_en),
        .pulse   (tick_pulse)
    );

    assign run_en    = (state_q == ST_RUN);
    assign start_acc = (state_q == ST_IDLE) && start && !abort;
    assign abort_run = (state_q == ST_RUN) && abort;
    assign cfg_ok    = cfg_we && (state_q != ST_RUN) && ({1'b0, cfg_addr} < NUM_PH_EXT);

    // A programmed duration of zero behaves like one tick.
    always_comb begin
        dur_cur   = dur_q[phase_q];
        dur_eff   = (dur_cur == '0) ? DUR_W'(1) : dur_cur;
        phase_end = tick_pulse && (tick_cnt_q == (dur_eff - DUR_W'(1)));
        final_end = phase_end && (phase_q == last_q);
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                dur_q[i] <= DUR_W'(1);
            end
        end else if (cfg_ok) begin
            dur_q[cfg_addr] <= cfg_dur;
        end
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (start_acc) begin
            last_q <= (seq_last > LAST_MAX) ? LAST_MAX : seq_last;
        end
    end

    // Phase holds through DONE so the final index stays visible for that cycle.
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            tick_cnt_q <= '0;
        end else if (start_acc || abort_run || (state_q == ST_DONE)) begin
            phase_q    <= '0;
            tick_cnt_q <= '0;
        end else if (run_en && tick_pulse) begin
            if (phase_end) begin
                tick_cnt_q <= '0;
                if (!final_end) begin
                    phase_q <= phase_q + PH_W'(1);
                end
            end else begin
                tick_cnt_q <= tick_cnt_q + DUR_W'(1);
            end
        end
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_acc) state_d = ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (final_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        phase = phase_q;
        unique case (state_q)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer at DIV=4: a 4-phase instance for the main
// sequences and a 3-phase instance for seq_last clamping.
module tb_tick_sequencer;

    logic src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_dur;
    logic [1:0] seq_last;
    logic       start;
    logic       abort;

    logic       a_busy, a_tick, a_done;
    logic [1:0] a_phase;
    logic       b_busy, b_tick, b_done;
    logic [1:0] b_phase;

    logic       sel;
    logic       mon_busy, mon_tick, mon_done;
    logic [1:0] mon_phase;

    assign mon_busy  = sel ? b_busy  : a_busy;
    assign mon_tick  = sel ? b_tick  : a_tick;
    assign mon_done  = sel ? b_done  : a_done;
    assign mon_phase = sel ? b_phase : a_phase;

    tick_sequencer #(
        .SRC_FREQ   (4),
        .TICK_FREQ  (1),
        .NUM_PHASES (4),
        .DUR_W      (8)
    ) u_dut_a (
        .src_clk    (src_clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_dur    (cfg_dur),
        .seq_last   (seq_last),
        .start      (start),
        .abort      (abort),
        .busy       (a_busy),
        .phase      (a_phase),
        .tick_pulse (a_tick),
        .done       (a_done)
    );

    tick_sequencer #(
        .SRC_FREQ   (4),
        .TICK_FREQ  (1),
        .NUM_PHASES (3),
        .DUR_W      (8)
    ) u_dut_b (
        .src_clk    (src_clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_dur    (cfg_dur),
        .seq_last   (seq_last),
        .start      (start),
        .abort      (abort),
        .busy       (b_busy),
        .phase      (b_phase),
        .tick_pulse (b_tick),
        .done       (b_done)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    int m_busy, m_first_tick, m_ticks, m_gap_err;
    int m_done_at, m_done_cnt, m_timeout, m_restart;
    int m_ph [4];

    task automatic chk(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [7:0] val);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_dur  = val;
        @(negedge src_clk);
        cfg_we   = 1'b0;
    endtask

    // Starts a sequence and records per-cycle observations until three cycles
    // after done (or the budget runs out). Entered and left on a falling edge.
    task automatic measure(input logic [1:0] last, input int hold, input int wr_at);
        int last_tick;
        int after;
        m_busy = 0; m_first_tick = -1; m_ticks = 0; m_gap_err = 0;
        m_done_at = -1; m_done_cnt = 0; m_timeout = 1; m_restart = 0;
        for (int i = 0; i < 4; i++) m_ph[i] = 0;
        last_tick = -1;
        after     = 0;
        seq_last  = last;
        start     = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge src_clk);
            if (cyc >= hold) start = 1'b0;
            if (cyc == wr_at) begin
                cfg_we = 1'b1; cfg_addr = 2'd0; cfg_dur = 8'd9;
            end else begin
                cfg_we = 1'b0;
            end
            if (mon_busy) begin
                m_busy++;
                m_ph[mon_phase]++;
            end
            if (mon_tick) begin
                if (m_first_tick < 0) m_first_tick = cyc;
                else if (cyc - last_tick != 4) m_gap_err++;
                last_tick = cyc;
                m_ticks++;
            end
            if (mon_done) begin
                m_done_at = cyc;
                m_done_cnt++;
            end
            if (m_done_at > 0 && mon_busy) m_restart = 1;
            if (m_done_at > 0) begin
                after++;
                if (after == 4) begin
                    m_timeout = 0;
                    break;
                end
            end
        end
        start  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic chk_run(input string tag, input int busy_exp, input int p0, input int p1,
                           input int p2, input int p3, input int ticks_exp, input int done_exp);
        chk({tag, "_timeout"},    m_timeout,    0);
        chk({tag, "_busy_cyc"},   m_busy,       busy_exp);
        chk({tag, "_ph0_cyc"},    m_ph[0],      p0);
        chk({tag, "_ph1_cyc"},    m_ph[1],      p1);
        chk({tag, "_ph2_cyc"},    m_ph[2],      p2);
        chk({tag, "_ph3_cyc"},    m_ph[3],      p3);
        chk({tag, "_first_tick"}, m_first_tick, 4);
        chk({tag, "_ticks"},      m_ticks,      ticks_exp);
        chk({tag, "_tick_gap"},   m_gap_err,    0);
        chk({tag, "_done_at"},    m_done_at,    done_exp);
        chk({tag, "_done_cnt"},   m_done_cnt,   1);
        chk({tag, "_restart"},    m_restart,    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_dur = '0;
        seq_last = '0; start = 1'b0; abort = 1'b0; sel = 1'b0;
        repeat (2) @(negedge src_clk);
        chk("rst_busy",  a_busy,  0);
        chk("rst_phase", a_phase, 0);
        chk("rst_done",  a_done,  0);
        chk("rst_tick",  a_tick,  0);
        rst_n = 1'b1;
        @(negedge src_clk);
        chk("idle_busy", a_busy, 0);

        // default durations, two phases
        measure(2'd1, 1, 0);
        chk_run("dflt", 8, 4, 4, 0, 0, 2, 9);

        cfg_write(2'd0, 8'd3);
        cfg_write(2'd1, 8'd1);
        cfg_write(2'd2, 8'd2);
        cfg_write(2'd3, 8'd0);
        measure(2'd3, 1, 0);
        chk_run("prog", 28, 12, 4, 8, 4, 7, 29);

        // abort in RUN cycle 10, then immediate restart
        cfg_write(2'd0, 8'd5);
        seq_last = 2'd3;
        start    = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge src_clk);
            start = 1'b0;
        end
        chk("abort_pre_busy",  a_busy,  1);
        chk("abort_pre_phase", a_phase, 0);
        abort = 1'b1;
        @(negedge src_clk);
        abort = 1'b0;
        chk("abort_busy",  a_busy,  0);
        chk("abort_phase", a_phase, 0);
        chk("abort_done",  a_done,  0);
        measure(2'd0, 1, 0);
        chk_run("restart", 20, 20, 0, 0, 0, 5, 21);

        // write during RUN ignored, start held through RUN
        measure(2'd0, 10, 3);
        chk_run("runwr", 20, 20, 0, 0, 0, 5, 21);
        measure(2'd0, 1, 0);
        chk_run("olddur", 20, 20, 0, 0, 0, 5, 21);
        cfg_write(2'd0, 8'd2);
        measure(2'd0, 1, 0);
        chk_run("newdur", 8, 8, 0, 0, 0, 2, 9);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge src_clk);
        chk("sa_busy1", a_busy, 0);
        @(negedge src_clk);
        chk("sa_busy2", a_busy, 0);
        start = 1'b0; abort = 1'b0;
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge src_clk);
            if (a_busy || a_done) n_done++;
        end
        chk("sa_quiet", n_done, 0);

        // reset mid phase 2; durations now {2,1,2,0} -> phase 2 spans cycles 13..20
        seq_last = 2'd3;
        start    = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge src_clk);
            start = 1'b0;
        end
        chk("midrst_pre_phase", a_phase, 2);
        chk("midrst_pre_busy",  a_busy,  1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",  a_busy,  0);
        chk("midrst_phase", a_phase, 0);
        chk("midrst_done",  a_done,  0);
        chk("midrst_tick",  a_tick,  0);
        @(negedge src_clk);
        rst_n = 1'b1;
        @(negedge src_clk);
        measure(2'd3, 1, 0);
        chk_run("postrst", 16, 4, 4, 4, 4, 4, 17);

        // 3-phase instance clamps seq_last=3 to 2
        sel = 1'b1;
        #1;
        measure(2'd3, 1, 0);
        chk_run("clamp", 12, 4, 4, 4, 0, 3, 13);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
